// File: rtl/uart_pkg.sv
// Shared receiver types and constants for the UART RX path.
// No logic of its own; imported by the FIFO and the RX controller.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int UART_DATA_W          = 8;
  localparam int BAUD_CNT_W           = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Counter reload for the half-bit wait from start edge to start-bit centre.
  function automatic logic [BAUD_CNT_W-1:0] half_bit_load(input int clks_per_bit);
    return BAUD_CNT_W'(clks_per_bit / 2 - 1);
  endfunction

  function automatic logic [BAUD_CNT_W-1:0] full_bit_load(input int clks_per_bit);
    return BAUD_CNT_W'(clks_per_bit - 1);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small first-word-fall-through byte buffer; write lands on head one cycle after push.
// Push into a full FIFO is refused unless a pop happens in the same cycle; pop on empty is ignored.
module uart_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so stale entries never leak out.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: 2-flop sync, bit-centre sampling, byte appears on o_data/o_valid 1 cycle after stop sample.
// Reader drains via o_valid/i_rd; bytes arriving while the buffer is full are dropped and flagged as overrun.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx,
  input  logic                   i_rd,
  input  logic                   i_clr,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_frame_err,
  output logic                   o_overrun,
  output logic                   o_busy
);

  localparam logic [BAUD_CNT_W-1:0] HALF_LOAD = half_bit_load(CLKS_PER_BIT);
  localparam logic [BAUD_CNT_W-1:0] BIT_LOAD  = full_bit_load(CLKS_PER_BIT);

  logic                   rx_meta;
  logic                   rx_s;
  rx_state_t              state;
  logic [BAUD_CNT_W-1:0]  cnt;
  logic [2:0]             idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   busy;
  logic                   frame_err;
  logic                   overrun;
  logic                   sample;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_head;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  assign sample = (cnt == '0);
  // Only a clean stop bit delivers the byte; the FIFO captures it on this edge.
  assign push   = (state == STOP) && sample && rx_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF_LOAD;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (sample) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= BIT_LOAD;
              idx   <= '0;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shreg[idx] <= rx_s;
            idx        <= idx + 1'b1;
            cnt        <= BIT_LOAD;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (sample) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end
        end
        BREAK: begin
          // Held-low line must return high before another start can be seen.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if ((state == STOP) && sample && !rx_s) begin
        frame_err <= 1'b1;
      end else if (i_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overrun <= 1'b0;
    end else if (push && fifo_full && !(i_rd && !fifo_empty)) begin
      overrun <= 1'b1;
    end else if (i_clr) begin
      overrun <= 1'b0;
    end
  end

  uart_fifo #(
    .DATA_W (UART_DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (shreg),
    .pop       (i_rd),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_data      = fifo_head;
  assign o_valid     = !fifo_empty;
  assign o_frame_err = frame_err;
  assign o_overrun   = overrun;
  assign o_busy      = busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit with a 4-entry buffer.
module tb_uart_rx_ctrl;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_rx;
  logic       i_rd;
  logic       i_clr;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .i_rd        (i_rd),
    .i_clr       (i_clr),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Line level for cycle c of a frame: {stop, data[7:0], start}, then tail after the frame.
  task automatic drive(input logic [9:0] f, input logic tail, input int from, input int to);
    for (int c = from; c < to; c++) begin
      i_rx = (c < FRAME) ? f[c / CPB] : tail;
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    drive({1'b1, b, 1'b0}, 1'b1, 0, FRAME);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {7'd0, o_valid}, 8'd1);
    chk({tag, "_data"}, o_data, exp);
    i_rd = 1'b1;
    tick(1);
    i_rd = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_rx  = 1'b1;
    i_rd  = 1'b0;
    i_clr = 1'b0;
    tick(3);
    i_rst = 1'b0;
    tick(2);

    chk("rst_valid", {7'd0, o_valid}, 8'd0);
    chk("rst_data", o_data, 8'h00);
    chk("rst_busy", {7'd0, o_busy}, 8'd0);
    chk("rst_ferr", {7'd0, o_frame_err}, 8'd0);
    chk("rst_ovr", {7'd0, o_overrun}, 8'd0);

    // 1: single byte, push timing relative to the stop sample
    drive({1'b1, 8'hA5, 1'b0}, 1'b1, 0, 40);
    chk("t1_busy_data", {7'd0, o_busy}, 8'd1);
    drive({1'b1, 8'hA5, 1'b0}, 1'b1, 40, 154);
    chk("t1_valid_pre", {7'd0, o_valid}, 8'd0);
    drive({1'b1, 8'hA5, 1'b0}, 1'b1, 154, 155);
    chk("t1_valid_post", {7'd0, o_valid}, 8'd1);
    chk("t1_data", o_data, 8'hA5);
    chk("t1_ferr", {7'd0, o_frame_err}, 8'd0);
    chk("t1_ovr", {7'd0, o_overrun}, 8'd0);
    drive({1'b1, 8'hA5, 1'b0}, 1'b1, 155, FRAME);
    chk("t1_busy_end", {7'd0, o_busy}, 8'd0);
    i_rd = 1'b1;
    tick(1);
    i_rd = 1'b0;
    chk("t1_valid_popped", {7'd0, o_valid}, 8'd0);

    // 2: short glitch rejected at start-bit centre
    i_rx = 1'b0;
    tick(5);
    i_rx = 1'b1;
    chk("t2_busy_start", {7'd0, o_busy}, 8'd1);
    tick(7);
    chk("t2_busy_idle", {7'd0, o_busy}, 8'd0);
    chk("t2_valid", {7'd0, o_valid}, 8'd0);
    chk("t2_ferr", {7'd0, o_frame_err}, 8'd0);
    tick(20);

    // 3: framing error with held-low line, then recovery
    drive({1'b0, 8'h3C, 1'b0}, 1'b0, 0, 156);
    chk("t3_ferr", {7'd0, o_frame_err}, 8'd1);
    chk("t3_valid", {7'd0, o_valid}, 8'd0);
    chk("t3_busy_break", {7'd0, o_busy}, 8'd1);
    drive({1'b0, 8'h3C, 1'b0}, 1'b0, 156, 200);
    chk("t3_busy_held", {7'd0, o_busy}, 8'd1);
    chk("t3_valid_held", {7'd0, o_valid}, 8'd0);
    drive({1'b0, 8'h3C, 1'b0}, 1'b1, 200, 206);
    chk("t3_busy_release", {7'd0, o_busy}, 8'd0);
    send(8'h81);
    chk("t3_ferr_sticky", {7'd0, o_frame_err}, 8'd1);
    pop_expect("t3_byte", 8'h81);
    i_clr = 1'b1;
    tick(1);
    i_clr = 1'b0;
    chk("t3_ferr_clr", {7'd0, o_frame_err}, 8'd0);

    // 4: overrun when a fifth byte arrives unread
    for (int b = 1; b <= 4; b++) send(8'(b));
    chk("t4_ovr_full", {7'd0, o_overrun}, 8'd0);
    send(8'h05);
    chk("t4_ovr", {7'd0, o_overrun}, 8'd1);
    pop_expect("t4_pop1", 8'h01);
    pop_expect("t4_pop2", 8'h02);
    pop_expect("t4_pop3", 8'h03);
    pop_expect("t4_pop4", 8'h04);
    chk("t4_empty", {7'd0, o_valid}, 8'd0);
    i_rd = 1'b1;
    tick(1);
    i_rd = 1'b0;
    chk("t4_rd_empty_valid", {7'd0, o_valid}, 8'd0);
    chk("t4_rd_empty_data", o_data, 8'h00);
    i_clr = 1'b1;
    tick(1);
    i_clr = 1'b0;
    chk("t4_ovr_clr", {7'd0, o_overrun}, 8'd0);

    // 5: pop coincident with push into a full buffer
    for (int b = 1; b <= 4; b++) send(8'(b));
    drive({1'b1, 8'h77, 1'b0}, 1'b1, 0, 154);
    i_rd = 1'b1;
    drive({1'b1, 8'h77, 1'b0}, 1'b1, 154, 155);
    i_rd = 1'b0;
    chk("t5_ovr", {7'd0, o_overrun}, 8'd0);
    drive({1'b1, 8'h77, 1'b0}, 1'b1, 155, FRAME);
    pop_expect("t5_pop1", 8'h02);
    pop_expect("t5_pop2", 8'h03);
    pop_expect("t5_pop3", 8'h04);
    pop_expect("t5_pop4", 8'h77);
    chk("t5_empty", {7'd0, o_valid}, 8'd0);

    // 6: reset mid-frame with a byte already buffered
    send(8'h11);
    chk("t6_pre_valid", {7'd0, o_valid}, 8'd1);
    drive({1'b1, 8'hFF, 1'b0}, 1'b1, 0, 80);
    chk("t6_pre_busy", {7'd0, o_busy}, 8'd1);
    i_rst = 1'b1;
    drive({1'b1, 8'hFF, 1'b0}, 1'b1, 80, 81);
    i_rst = 1'b0;
    chk("t6_rst_valid", {7'd0, o_valid}, 8'd0);
    chk("t6_rst_data", o_data, 8'h00);
    chk("t6_rst_busy", {7'd0, o_busy}, 8'd0);
    drive({1'b1, 8'hFF, 1'b0}, 1'b1, 81, FRAME);
    chk("t6_no_partial", {7'd0, o_valid}, 8'd0);
    chk("t6_no_busy", {7'd0, o_busy}, 8'd0);
    send(8'h5A);
    pop_expect("t6_byte", 8'h5A);
    chk("t6_ferr", {7'd0, o_frame_err}, 8'd0);
    chk("t6_ovr", {7'd0, o_overrun}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
